// File: rtl/register.sv
// Register file with two combinational read ports and one synchronous write port.
// Register 0 is hardwired to zero. Define REGISTER_BYPASS_EN for write-first forwarding.
module register #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [WIDTH-1:0]  wd3,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             wr_en;

  // Writes to address 0 (or beyond DEPTH) are dropped so x0 stays zero.
  assign wr_en = we3 && (a3 != '0) && (int'(a3) < DEPTH);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[a3] = wd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REGISTER_BYPASS_EN
  logic fwd_en;
  // Reset gates forwarding because the write it would expose is discarded.
  assign fwd_en = wr_en && !reset;
`endif

  always_comb begin
    rd1 = '0;
    if ((a1 != '0) && (int'(a1) < DEPTH)) begin
      rd1 = regs_q[a1];
`ifdef REGISTER_BYPASS_EN
      if (fwd_en && (a1 == a3)) begin
        rd1 = wd3;
      end
`endif
    end
  end

  always_comb begin
    rd2 = '0;
    if ((a2 != '0) && (int'(a2) < DEPTH)) begin
      rd2 = regs_q[a2];
`ifdef REGISTER_BYPASS_EN
      if (fwd_en && (a2 == a3)) begin
        rd2 = wd3;
      end
`endif
    end
  end

endmodule

// File: tb/tb_register.sv
// Directed self-checking bench for the register file (default 32x32 configuration).
// Expected values come from hand-computed constants and a small shadow array.
module tb_register;

  localparam int W = 32;
  localparam int D = 32;

  logic         clk;
  logic         reset;
  logic         we3;
  logic [4:0]   a1;
  logic [4:0]   a2;
  logic [4:0]   a3;
  logic [W-1:0] wd3;
  logic [W-1:0] rd1;
  logic [W-1:0] rd2;

  int n_checks;
  int n_fails;
  logic [W-1:0] model [D];

  register #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .we3   (we3),
    .a1    (a1),
    .a2    (a2),
    .a3    (a3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one rising edge, then settle inputs away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [W-1:0] val);
    a3  = addr;
    wd3 = val;
    we3 = 1'b1;
    tick();
    we3 = 1'b0;
    if (addr != 5'd0) model[addr] = val;
  endtask

  task automatic read_check(input string tag, input logic [4:0] addr, input logic [W-1:0] exp);
    a1 = addr;
    a2 = addr;
    #1;
    check({tag, "_rd1"}, rd1, exp);
    check({tag, "_rd2"}, rd2, exp);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < D; i++) begin
      read_check(tag, 5'(i), model[i]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    for (int i = 0; i < D; i++) model[i] = '0;
    reset = 1'b1;
    we3   = 1'b0;
    a1    = '0;
    a2    = '0;
    a3    = '0;
    wd3   = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    sweep("reset_state");

    // two-edge write then read, port 1
    a3 = 5'd1; wd3 = 32'h12345678; we3 = 1'b1;
    tick(); tick();
    we3 = 1'b0; model[1] = 32'h12345678;
    a1 = 5'd1; #1;
    check("wr_r1", rd1, 32'h12345678);

    // port 2 read of reg 2 while port 1 holds reg 1
    a3 = 5'd2; wd3 = 32'h87654321; we3 = 1'b1;
    tick(); tick();
    we3 = 1'b0; model[2] = 32'h87654321;
    a1 = 5'd1; a2 = 5'd2; #1;
    check("wr_r2_rd2", rd2, 32'h87654321);
    check("wr_r2_rd1", rd1, 32'h12345678);

    // x0 ignores writes
    write_reg(5'd0, 32'hFFFFFFFF);
    read_check("x0", 5'd0, 32'h0);

    // both ports on the same register
    a1 = 5'd2; a2 = 5'd2; #1;
    check("same_addr_rd1", rd1, 32'h87654321);
    check("same_addr_rd2", rd2, 32'h87654321);

    // fill remaining registers with distinct patterns, then verify isolation
    for (int i = 3; i < D; i++) begin
      write_reg(5'(i), {8'(i), 8'hC3, 8'(~i), 8'(i * 7)});
    end
    sweep("fill");

    // we3=0 edges must not disturb anything
    a3 = 5'd9; wd3 = 32'hDEADBEEF; we3 = 1'b0;
    tick(); tick();
    read_check("we0_r9", 5'd9, model[9]);
    read_check("we0_r31", 5'd31, model[31]);

    // same-cycle read of the address being written
    write_reg(5'd5, 32'h1);
    a3 = 5'd5; wd3 = 32'h2; we3 = 1'b1;
    a1 = 5'd5; a2 = 5'd6; #1;
`ifdef REGISTER_BYPASS_EN
    check("same_cycle_rd1", rd1, 32'h2);
`else
    check("same_cycle_rd1", rd1, 32'h1);
`endif
    check("same_cycle_other", rd2, model[6]);
    tick();
    we3 = 1'b0; model[5] = 32'h2;
    a1 = 5'd5; #1;
    check("after_edge_r5", rd1, 32'h2);

    // mid-operation reset clears everything
    a1 = 5'd1; a2 = 5'd2; #1;
    check("pre_reset_r1", rd1, 32'h12345678);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < D; i++) model[i] = '0;
    a1 = 5'd1; a2 = 5'd2; #1;
    check("reset_r1", rd1, 32'h0);
    check("reset_r2", rd2, 32'h0);

    // reset beats a simultaneous write, and no forwarding while reset is high
    reset = 1'b1; we3 = 1'b1; a3 = 5'd3; wd3 = 32'hA5A5A5A5;
    a1 = 5'd3; #1;
    check("reset_wr_nofwd", rd1, 32'h0);
    tick();
    reset = 1'b0; we3 = 1'b0;
    read_check("reset_wr_r3", 5'd3, 32'h0);

    // first edge after reset accepts writes
    write_reg(5'd4, 32'h0BADF00D);
    read_check("post_reset_r4", 5'd4, 32'h0BADF00D);
    sweep("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
